// File: rtl/mcycle_alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mcycle_alu_pkg : opcode encoding, FSM state type and latency constants     |
// |                  shared by the multi-cycle ALU and its testbench.          |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
package mcycle_alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_ADDU  = 5'd1,
        OP_SUB   = 5'd2,
        OP_SUBU  = 5'd3,
        OP_AND   = 5'd4,
        OP_OR    = 5'd5,
        OP_XOR   = 5'd6,
        OP_NOR   = 5'd7,
        OP_SLA   = 5'd8,
        OP_SRAI  = 5'd9,
        OP_SLT   = 5'd10,
        OP_SLTU  = 5'd11,
        OP_SQRT  = 5'd12,
        OP_MULT  = 5'd13,
        OP_MULTU = 5'd14,
        OP_DIV   = 5'd15,
        OP_DIVU  = 5'd16,
        OP_ADDI  = 5'd17,
        OP_ADDIU = 5'd18,
        OP_ANDI  = 5'd19,
        OP_ORI   = 5'd20,
        OP_SLTI  = 5'd21
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int LAT_SINGLE = 1;

    function automatic int lat_muldiv(input int width);
        return width + 1;
    endfunction

    function automatic int lat_sqrt(input int width);
        return width / 2 + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcycle_alu_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mcycle_alu_divider : iterative unsigned restoring divider, one quotient    |
// |                      bit per cycle; o_done holds until the next i_start.   |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
module mcycle_alu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_done,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int c_CW = $clog2(WIDTH + 1);

    logic             r_busy;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_den;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;

    // The dividend shifts out of r_quo while quotient bits shift in behind it.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_den};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_den  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= c_CW'(WIDTH);
            r_quo  <= i_dividend;
            r_rem  <= '0;
            r_den  <= i_divisor;
        end else if (r_busy && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_CW'(1);
            if (!w_diff[WIDTH]) begin
                r_rem <= w_diff[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign o_done      = r_busy && (r_cnt == '0);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/mcycle_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mcycle_alu : multi-cycle ALU with shift-add multiply, iterative divide and |
// |              optional square root (enabled by MCYCLE_ALU_SQRT_EN).         |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
module mcycle_alu
    import mcycle_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [15:0]      immediate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             zero,
    output logic             overflow,
    output logic             neg
);

    localparam int             c_SHW = $clog2(WIDTH);
    localparam int             c_CW  = $clog2(WIDTH + 1);
    localparam int             c_M   = WIDTH - 1;
    localparam logic [c_M:0]   c_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    state_t             r_state, w_state_nxt;
    opcode_t            r_op;
    logic [WIDTH-1:0]   r_a, r_b;
    logic [15:0]        r_imm;
    logic [c_CW-1:0]    r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_c, r_hi, r_lo;
    logic               r_zero, r_ovf, r_neg;

    opcode_t            w_op_in;
    logic               w_accept, w_exec_done, w_is_div, w_is_mul, w_def;
    logic               w_div_start, w_div_done;
    logic [WIDTH-1:0]   w_a_abs, w_b_abs, w_div_q, w_div_r, w_dq, w_dr;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_sum, w_dif, w_imm_s, w_imm_z, w_addi;
    logic [63:0]        w_imm_s64;
    logic [WIDTH-1:0]   w_c, w_hi, w_lo;
    logic               w_zero, w_ovf, w_neg;

    assign w_op_in  = opcode_t'(opcode);
    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign in_ready = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);

    // Signed mult/div run on magnitudes; the sign is restored from r_a/r_b at the end.
    assign w_a_abs = ((w_op_in == OP_MULT || w_op_in == OP_DIV) && a[c_M]) ? -a : a;
    assign w_b_abs = ((w_op_in == OP_MULT || w_op_in == OP_DIV) && b[c_M]) ? -b : b;

    assign w_div_start = w_accept && (w_op_in == OP_DIV || w_op_in == OP_DIVU);
    assign w_is_div    = (r_op == OP_DIV) || (r_op == OP_DIVU);
    assign w_is_mul    = (r_op == OP_MULT) || (r_op == OP_MULTU);
    assign w_exec_done = w_is_div ? w_div_done : (r_cnt == '0);

    mcycle_alu_divider #(.WIDTH(WIDTH)) u_divider (
        .clk         (clk),
        .rst         (reset),
        .i_start     (w_div_start),
        .i_dividend  (w_a_abs),
        .i_divisor   (w_b_abs),
        .o_done      (w_div_done),
        .o_quotient  (w_div_q),
        .o_remainder (w_div_r)
    );

    assign w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod    = ((r_op == OP_MULT) && (r_a[c_M] ^ r_b[c_M])) ? -r_prod : r_prod;
    assign w_dq      = (r_a[c_M] ^ r_b[c_M]) ? -w_div_q : w_div_q;
    assign w_dr      = r_a[c_M] ? -w_div_r : w_div_r;

`ifdef MCYCLE_ALU_SQRT_EN
    localparam int          c_RW = WIDTH / 2 + 3;
    logic [WIDTH-1:0]       r_sq_rad;
    logic [WIDTH/2-1:0]     r_sq_root;
    logic [c_RW-1:0]        r_sq_rem;
    logic [c_RW-1:0]        w_sq_cat, w_sq_trial;
    logic                   w_sq_ge;

    // Digit-by-digit root: two radicand bits per step, trial divisor 4*root+1.
    assign w_sq_cat   = {r_sq_rem[c_RW-3:0], r_sq_rad[WIDTH-1 -: 2]};
    assign w_sq_trial = c_RW'({r_sq_root, 2'b01});
    assign w_sq_ge    = (w_sq_cat >= w_sq_trial);
`endif

    assign w_imm_s64 = {{48{r_imm[15]}}, r_imm};
    assign w_imm_s   = w_imm_s64[WIDTH-1:0];
    assign w_imm_z   = WIDTH'({48'd0, r_imm});
    assign w_sum     = r_a + r_b;
    assign w_dif     = r_a - r_b;
    assign w_addi    = r_a + w_imm_s;

    always_comb begin
        w_c   = '0;
        w_hi  = '0;
        w_lo  = '0;
        w_ovf = 1'b0;
        w_neg = 1'b0;
        w_def = 1'b1;
        case (r_op)
            OP_ADD: begin
                w_c   = w_sum;
                w_ovf = (r_a[c_M] == r_b[c_M]) && (w_sum[c_M] != r_a[c_M]);
                w_neg = w_sum[c_M];
            end
            OP_ADDU: w_c = w_sum;
            OP_SUB: begin
                w_c   = w_dif;
                w_ovf = (r_a[c_M] != r_b[c_M]) && (w_dif[c_M] != r_a[c_M]);
                w_neg = w_dif[c_M];
            end
            OP_SUBU: begin
                w_c   = w_dif;
                w_neg = (r_a < r_b);
            end
            OP_AND:  begin w_c = r_a & r_b;    w_neg = w_c[c_M]; end
            OP_OR:   begin w_c = r_a | r_b;    w_neg = w_c[c_M]; end
            OP_XOR:  begin w_c = r_a ^ r_b;    w_neg = w_c[c_M]; end
            OP_NOR:  begin w_c = ~(r_a | r_b); w_neg = w_c[c_M]; end
            OP_SLA:  begin w_c = r_a << r_b[c_SHW-1:0]; w_neg = w_c[c_M]; end
            OP_SRAI: begin w_c = $unsigned($signed(r_a) >>> r_b[c_SHW-1:0]); w_neg = w_c[c_M]; end
            OP_SLT:  w_c = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            OP_SLTU: w_c = {{(WIDTH-1){1'b0}}, (r_a < r_b)};
            OP_MULT, OP_MULTU: begin
                w_hi  = w_prod[2*WIDTH-1:WIDTH];
                w_lo  = w_prod[WIDTH-1:0];
                w_c   = w_lo;
                w_neg = (r_op == OP_MULT) && w_prod[2*WIDTH-1];
            end
            OP_DIV: begin
                if (r_b == '0) begin
                    w_lo  = '1;
                    w_hi  = r_a;
                    w_ovf = 1'b1;
                end else if ((r_a == c_MIN) && (r_b == '1)) begin
                    w_lo  = c_MIN;
                    w_ovf = 1'b1;
                end else begin
                    w_lo = w_dq;
                    w_hi = w_dr;
                end
                w_c   = w_lo;
                w_neg = w_lo[c_M];
            end
            OP_DIVU: begin
                if (r_b == '0) begin
                    w_lo  = '1;
                    w_hi  = r_a;
                    w_ovf = 1'b1;
                end else begin
                    w_lo = w_div_q;
                    w_hi = w_div_r;
                end
                w_c = w_lo;
            end
            OP_ADDI: begin
                w_c   = w_addi;
                w_ovf = (r_a[c_M] == w_imm_s[c_M]) && (w_addi[c_M] != r_a[c_M]);
                w_neg = w_addi[c_M];
            end
            OP_ADDIU: w_c = r_a + w_imm_z;
            OP_ANDI:  begin w_c = r_a & w_imm_z; w_neg = w_c[c_M]; end
            OP_ORI:   begin w_c = r_a | w_imm_z; w_neg = w_c[c_M]; end
            OP_SLTI:  w_c = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(w_imm_s))};
`ifdef MCYCLE_ALU_SQRT_EN
            OP_SQRT: begin
                w_c  = WIDTH'(r_sq_root);
                w_hi = WIDTH'(r_sq_rem);
            end
`endif
            default: w_def = 1'b0;
        endcase
        w_zero = w_def && (w_is_mul ? (w_prod == '0) : (w_c == '0));
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)    w_state_nxt = ST_EXEC;
            ST_EXEC: if (w_exec_done) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready)   w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= OP_ADD;
            r_a     <= '0;
            r_b     <= '0;
            r_imm   <= '0;
            r_cnt   <= '0;
            r_prod  <= '0;
            r_mcand <= '0;
            r_c     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_zero  <= 1'b0;
            r_ovf   <= 1'b0;
            r_neg   <= 1'b0;
`ifdef MCYCLE_ALU_SQRT_EN
            r_sq_rad  <= '0;
            r_sq_root <= '0;
            r_sq_rem  <= '0;
`endif
        end else if (w_accept) begin
            r_op    <= w_op_in;
            r_a     <= a;
            r_b     <= b;
            r_imm   <= immediate;
            r_prod  <= {{WIDTH{1'b0}}, w_b_abs};
            r_mcand <= w_a_abs;
            case (w_op_in)
                OP_MULT, OP_MULTU: r_cnt <= c_CW'(lat_muldiv(WIDTH) - 1);
`ifdef MCYCLE_ALU_SQRT_EN
                OP_SQRT:           r_cnt <= c_CW'(lat_sqrt(WIDTH) - 1);
`endif
                default:           r_cnt <= c_CW'(LAT_SINGLE - 1);
            endcase
`ifdef MCYCLE_ALU_SQRT_EN
            r_sq_rad  <= a;
            r_sq_root <= '0;
            r_sq_rem  <= '0;
`endif
        end else if (r_state == ST_EXEC) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - c_CW'(1);
`ifdef MCYCLE_ALU_SQRT_EN
                if (r_op == OP_SQRT) begin
                    r_sq_rem  <= w_sq_ge ? (w_sq_cat - w_sq_trial) : w_sq_cat;
                    r_sq_root <= {r_sq_root[WIDTH/2-2:0], w_sq_ge};
                    r_sq_rad  <= r_sq_rad << 2;
                end else
`endif
                r_prod <= {w_mul_sum, r_prod[WIDTH-1:1]};
            end
            if (w_exec_done) begin
                r_c    <= w_c;
                r_hi   <= w_hi;
                r_lo   <= w_lo;
                r_zero <= w_zero;
                r_ovf  <= w_ovf;
                r_neg  <= w_neg;
            end
        end
    end

    assign c        = r_c;
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign zero     = r_zero;
    assign overflow = r_ovf;
    assign neg      = r_neg;

endmodule
`default_nettype wire

// File: tb/tb_mcycle_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mcycle_alu : scoreboard bench for mcycle_alu (WIDTH=32), directed and   |
// |                 random requests against an arithmetic reference model.     |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mcycle_alu;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic [4:0]  opcode;
    logic [31:0] a, b, c, hi, lo;
    logic [15:0] immediate;
    logic        zero, overflow, neg;

    always #5 clk = ~clk;

    mcycle_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .immediate(immediate),
        .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .hi(hi), .lo(lo), .zero(zero), .overflow(overflow), .neg(neg)
    );

    typedef struct {
        logic [31:0] c, hi, lo;
        bit          z, o, n;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0, errors = 0;
    int   cycle = 0, hold_n = 0, last_hs = -1, last_acc = -1;
    bit   seen = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(logic [31:0] ec, ehi, elo, bit ez, eo, en, int lat);
        exp_t e;
        e.c = ec; e.hi = ehi; e.lo = elo; e.z = ez; e.o = eo; e.n = en; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    // Reference model: results from plain integer arithmetic on 64-bit values.
    function automatic exp_t model(int op, logic [31:0] x, logic [31:0] y, logic [15:0] im);
        exp_t        e;
        longint      sx = $signed(x), sy = $signed(y), s, qq, rr, rt, t;
        logic [31:0] ims = {{16{im[15]}}, im}, imz = {16'd0, im};
        logic [63:0] p = 64'd0;
        bit          def = 1'b1, mz = 1'b0;
        e = mk(0, 0, 0, 0, 0, 0, 1);
        case (op)
            0:  begin s = sx + sy; e.c = s[31:0]; e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); e.n = e.c[31]; end
            1:  e.c = x + y;
            2:  begin s = sx - sy; e.c = s[31:0]; e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); e.n = e.c[31]; end
            3:  begin e.c = x - y; e.n = (x < y); end
            4:  begin e.c = x & y; e.n = e.c[31]; end
            5:  begin e.c = x | y; e.n = e.c[31]; end
            6:  begin e.c = x ^ y; e.n = e.c[31]; end
            7:  begin e.c = ~(x | y); e.n = e.c[31]; end
            8:  begin e.c = x << y[4:0]; e.n = e.c[31]; end
            9:  begin e.c = $signed(x) >>> y[4:0]; e.n = e.c[31]; end
            10: e.c = (sx < sy) ? 32'd1 : 32'd0;
            11: e.c = (x < y) ? 32'd1 : 32'd0;
            12: begin
`ifdef MCYCLE_ALU_SQRT_EN
                rt = 0;
                for (int k = 15; k >= 0; k--) begin
                    t = rt | (64'sd1 <<< k);
                    if (t * t <= longint'({32'd0, x})) rt = t;
                end
                e.c = rt[31:0];
                s = longint'({32'd0, x}) - rt * rt;
                e.hi = s[31:0];
                e.lat = 17;
`else
                def = 1'b0;
`endif
            end
            13, 14: begin
                if (op == 13) p = sx * sy;
                else          p = {32'd0, x} * {32'd0, y};
                e.hi = p[63:32]; e.lo = p[31:0]; e.c = e.lo;
                e.n = (op == 13) && p[63]; mz = 1'b1; e.lat = 33;
            end
            15, 16: begin
                e.lat = 33;
                if (y == 0) begin
                    e.lo = 32'hFFFF_FFFF; e.hi = x; e.o = 1'b1;
                end else if (op == 15 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000; e.hi = 0; e.o = 1'b1;
                end else if (op == 15) begin
                    qq = sx / sy; rr = sx % sy; e.lo = qq[31:0]; e.hi = rr[31:0];
                end else begin
                    e.lo = x / y; e.hi = x % y;
                end
                e.c = e.lo;
                e.n = (op == 15) && e.lo[31];
            end
            17: begin s = sx + longint'($signed(ims)); e.c = s[31:0]; e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648); e.n = e.c[31]; end
            18: e.c = x + imz;
            19: begin e.c = x & imz; e.n = e.c[31]; end
            20: begin e.c = x | imz; e.n = e.c[31]; end
            21: e.c = (sx < longint'($signed(ims))) ? 32'd1 : 32'd0;
            default: def = 1'b0;
        endcase
        e.z = def && (mz ? (p == 64'd0) : (e.c == 32'd0));
        return e;
    endfunction

    task automatic issue(input int op, input logic [31:0] x, input logic [31:0] y,
                         input logic [15:0] im, input bit use_exp, input exp_t ex);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout actual in_ready=0 required in_ready=1");
            return;
        end
        opcode = 5'(op); a = x; b = y; immediate = im; in_valid = 1'b1;
        last_acc = cycle + 1;
        if (use_exp) begin
            ex.acc = cycle + 1;
            q.push_back(ex);
        end
        @(negedge clk);
        in_valid = 1'b0; a = $urandom; b = $urandom; immediate = 16'($urandom); opcode = 5'($urandom);
    endtask

    task automatic go(input int op, input logic [31:0] x, input logic [31:0] y, input logic [15:0] im);
        issue(op, x, y, im, 1'b1, model(op, x, y, im));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares each presented result and randomly back-pressures it.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                seen = 1'b0;
                out_ready = 1'b0;
            end else if (out_valid) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result actual c=%h required no result", c);
                    out_ready = 1'b1;
                end else begin
                    mon_e = q[0];
                    if (!seen) begin
                        seen = 1'b1;
                        chk("latency", 128'(cycle - mon_e.acc), 128'(mon_e.lat));
                        chk("c", c, mon_e.c);
                        chk("hi", hi, mon_e.hi);
                        chk("lo", lo, mon_e.lo);
                        chk("flags_zon", {zero, overflow, neg}, {mon_e.z, mon_e.o, mon_e.n});
                        chk("in_ready_busy", in_ready, 1'b0);
                    end else begin
                        chk("hold", {c, hi, lo, zero, overflow, neg, in_ready},
                            {mon_e.c, mon_e.hi, mon_e.lo, mon_e.z, mon_e.o, mon_e.n, 1'b0});
                    end
                    if (hold_n > 0) begin
                        hold_n--;
                        out_ready = 1'b0;
                    end else begin
                        out_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (out_ready) begin
                        last_hs = cycle + 1;
                        void'(q.pop_front());
                        seen = 1'b0;
                    end
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   any_valid;
        int   n;
        reset = 1'b1; in_valid = 1'b0; opcode = 5'd0; a = 0; b = 0; immediate = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {out_valid, in_ready, c, hi, lo, zero, overflow, neg},
            {1'b0, 1'b1, 32'd0, 32'd0, 32'd0, 3'b000});
        reset = 1'b0;

        issue(0, 32'h7FFF_FFFF, 32'd1, 16'd0, 1'b1, mk(32'h8000_0000, 0, 0, 0, 1, 1, 1));
        issue(13, -32'sd3, 32'd5, 16'd0, 1'b1,
              mk(32'hFFFF_FFF1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 0, 1, 33));
        issue(15, -32'sd7, 32'd2, 16'd0, 1'b1,
              mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 1, 33));
        issue(15, 32'd5, 32'd0, 16'd0, 1'b1,
              mk(32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 0, 1, 1, 33));
        issue(15, 32'h8000_0000, 32'hFFFF_FFFF, 16'd0, 1'b1,
              mk(32'h8000_0000, 0, 32'h8000_0000, 0, 1, 1, 33));
        issue(2, 32'h8000_0000, 32'd1, 16'd0, 1'b1, mk(32'h7FFF_FFFF, 0, 0, 0, 1, 0, 1));
        issue(3, 32'd1, 32'd2, 16'd0, 1'b1, mk(32'hFFFF_FFFF, 0, 0, 0, 0, 1, 1));
        issue(17, 32'd5, 32'd0, 16'hFFFF, 1'b1, mk(32'd4, 0, 0, 0, 0, 0, 1));
        issue(14, 32'd0, 32'hDEAD_BEEF, 16'd0, 1'b1, mk(0, 0, 0, 1, 0, 0, 33));
        issue(9, 32'h8000_0000, 32'd31, 16'd0, 1'b1, mk(32'hFFFF_FFFF, 0, 0, 0, 0, 1, 1));
        issue(25, 32'd0, 32'd0, 16'd0, 1'b1, mk(0, 0, 0, 0, 0, 0, 1));
`ifdef MCYCLE_ALU_SQRT_EN
        issue(12, 32'd17, 32'd0, 16'd0, 1'b1, mk(32'd4, 32'd1, 0, 0, 0, 0, 17));
`else
        issue(12, 32'd17, 32'd0, 16'd0, 1'b1, mk(0, 0, 0, 0, 0, 0, 1));
`endif

        // Held result followed by a second request waiting behind it.
        hold_n = 10;
        go(4, 32'hF0F0_1234, 32'h0FF0_FFFF, 16'd0);
        go(1, 32'd7, 32'd9, 16'd0);
        chk("turnaround", 128'(last_acc > last_hs), 128'd1);

        // Reset in the middle of a divu discards it.
        issue(16, 32'd1000, 32'd7, 16'd0, 1'b0, mk(0, 0, 0, 0, 0, 0, 0));
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("in_ready_after_reset", {in_ready, out_valid, c, hi, lo, zero, overflow, neg},
            {1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 3'b000});
        any_valid = 1'b0;
        repeat (40) begin
            @(negedge clk);
            any_valid |= out_valid;
        end
        chk("reset_discard", any_valid, 1'b0);
        issue(1, 32'd2, 32'd3, 16'd0, 1'b1, mk(32'd5, 0, 0, 0, 0, 0, 1));

        for (int i = 0; i < 250; i++)
            go($urandom_range(0, 31), pick(), pick(), 16'($urandom));

        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 128'(q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mcycle_alu.md
MCYCLE_ALU -- requirements
Module: mcycle_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; legal values are even numbers from 8 to 64.
REQ-002 SHALL have port clk, input, 1 bit, the only clock; all logic is rising-edge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1 bit, request valid.
REQ-005 SHALL have port in_ready, output, 1 bit, the block can accept a request.
REQ-006 SHALL have port opcode, input, 5 bits, operation select: the 22 codes 0..21, encoded per the shared package.
REQ-007 SHALL have ports a and b, input, WIDTH bits each, operands.
REQ-008 SHALL have port immediate, input, 16 bits, immediate for the addi/addiu/andi/ori/slti codes.
REQ-009 SHALL have port out_valid, output, 1 bit, result valid.
REQ-010 SHALL have port out_ready, input, 1 bit, consumer accepts the result.
REQ-011 SHALL have ports c, hi and lo, output, WIDTH bits each, result, high product/remainder, and low product/quotient.
REQ-012 SHALL have ports zero, overflow and neg, output, 1 bit each, result flags.

Function
REQ-013 SHALL implement FSM IDLE->EXEC->DONE->IDLE: accept on in_valid&&in_ready; leave DONE on out_ready; in_ready=1 only in IDLE.
REQ-014 SHALL register a, b, opcode and immediate at acceptance; later input changes have no effect on that request.
REQ-015 SHALL assert out_valid exactly 1 cycle after acceptance for the logic, add/sub, shift, slt and immediate codes (EXEC lasts one cycle).
REQ-016 SHALL assert out_valid WIDTH+1 cycles after acceptance for mult, multu, div and divu (iterative, one bit per cycle).
REQ-017 SHALL hold c, hi, lo and the flags stable while out_valid=1 and out_ready=0.
REQ-018 SHALL sign-extend immediate for addi/slti, zero-extend it for addiu/andi/ori, and zero-extend or truncate it to WIDTH.
REQ-019 SHALL set overflow for add/sub/addi on signed overflow; the unsigned codes never set it.
REQ-020 SHALL implement sla as a left shift and srai as an arithmetic right shift, by b[log2(WIDTH)-1:0] bits.
REQ-021 SHALL compute mult/multu with hi:lo = full 2*WIDTH product and c = lo.
REQ-022 SHALL truncate div toward zero, with lo = quotient, hi = remainder, and the remainder sign equal to the dividend sign.
REQ-023 SHALL, for division by zero, return lo=all-ones, hi=a, overflow=1.
REQ-024 SHALL, for signed div of MIN by -1, return lo=MIN, hi=0, overflow=1.
REQ-025 SHALL set zero when the primary result is all zeros (c; for mult/multu, the full hi:lo; for div/divu, lo).
REQ-026 SHALL set neg from the MSB of the primary result (lo for div), and for subu when a<b unsigned; it is 0 for other unsigned codes.
REQ-027 SHALL treat an undefined opcode as a 1-cycle op with c=hi=lo=0 and all flags 0.
REQ-028 SHALL allow a new acceptance in the cycle after a DONE handshake; there is no same-cycle turnaround.

Reset
REQ-029 SHALL, on reset, force the FSM to IDLE with in_ready=1 from the next cycle.
REQ-030 SHALL, on reset, drive out_valid=0, c=hi=lo=0 and zero=overflow=neg=0.
REQ-031 SHALL let reset mid-EXEC or mid-DONE discard the operation with no result ever presented.

Configuration
REQ-032 SHALL, with MCYCLE_ALU_SQRT_EN defined, implement opcode 12 (sqrt) as an iterative integer square root: c=floor(sqrt(unsigned a)), hi=remainder, latency WIDTH/2+1.
REQ-033 SHALL, without MCYCLE_ALU_SQRT_EN, treat opcode 12 as undefined per REQ-027.

Structure
REQ-034 SHALL place the opcode enumeration, FSM state type and latency constants in shared package mcycle_alu_pkg.
REQ-035 SHALL instantiate sub-module mcycle_alu_divider, an iterative unsigned restoring divider with start/done handshake; the top level handles sign correction.
REQ-036 SHALL use only shift-add hardware for mult; no wide combinational multiplier.

Verification (WIDTH=32)
REQ-037 SHALL cover: add 0x7FFFFFFF+1 -> c=0x80000000, overflow=1, neg=1, out_valid one cycle after accept.
REQ-038 SHALL cover: mult -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1, neg=1, out_valid 33 cycles after accept.
REQ-039 SHALL cover: div -7/2 -> lo=-3, hi=-1; div 5/0 -> lo=0xFFFFFFFF, hi=5, overflow=1.
REQ-040 SHALL cover: result held with out_ready=0 for 10 cycles -> out_valid and c stable, in_ready=0; second request accepted only after the handshake.
REQ-041 SHALL cover: reset asserted at cycle 10 of a divu -> out_valid never rises, in_ready=1 after reset, and the next addu 2+3 -> c=5.
REQ-042 SHALL cover: with MCYCLE_ALU_SQRT_EN, sqrt 17 -> c=4, hi=1 after 17 cycles; without it, c=0 after 1 cycle.
